// File: rtl/player_control_multi.sv
// rtl/player_control_multi.sv - player controller for the road-crossing game
//
// Grid movement from four direction switches, collision against NUM_CARS
// lane cars, multi-life tracking with post-hit invulnerability, BCD level
// counting and car-speed stepping, driven by a PLAY/HIT/LVL/OVER machine.
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   SW1..SW4     up / down / left / right switches (all four = soft restart)
//   car_x        flattened car x positions, car i at [10*i+9:10*i]
//   player_x     player left edge
//   player_y     player top edge
//   lives        thermometer code, LSB-aligned
//   level_tens   BCD tens digit of the level
//   level_units  BCD units digit of the level
//   speed_car    car speed step for the car generator
//   invulnerable high while in HIT
//   game_over    high while in OVER
module player_control_multi #(
  parameter int NUM_CARS      = 4,
  parameter int LIVES         = 4,
  parameter int STEP          = 32,
  parameter int MOVE_PERIOD   = 2500000,
  parameter int INVULN_CYCLES = 25000000,
  parameter int H_DISPLAY     = 640,
  parameter int V_DISPLAY     = 480,
  parameter int PLAYER_WIDTH  = 32,
  parameter int PLAYER_HEIGHT = 32,
  parameter int CAR_WIDTH     = 64,
  parameter int CAR_HEIGHT    = 32,
  parameter int LANE_Y0       = 64,
  parameter int LANE_PITCH    = 64,
  parameter int SPEED_MAX     = 31
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    SW1,
  input  logic                    SW2,
  input  logic                    SW3,
  input  logic                    SW4,
  input  logic [10*NUM_CARS-1:0]  car_x,
  output logic [9:0]              player_x,
  output logic [9:0]              player_y,
  output logic [LIVES-1:0]        lives,
  output logic [3:0]              level_tens,
  output logic [3:0]              level_units,
  output logic [4:0]              speed_car,
  output logic                    invulnerable,
  output logic                    game_over
);

  localparam int MC_W = $clog2(MOVE_PERIOD + 1);
  localparam int IC_W = $clog2(INVULN_CYCLES + 1);

  localparam logic [9:0]  SPAWN_X = 10'((H_DISPLAY - PLAYER_WIDTH) / 2);
  localparam logic [9:0]  SPAWN_Y = 10'(V_DISPLAY - PLAYER_HEIGHT);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] X_MAX   = 11'(H_DISPLAY - PLAYER_WIDTH);
  localparam logic [10:0] Y_MAX   = 11'(V_DISPLAY - PLAYER_HEIGHT);
  localparam logic [10:0] PW11    = 11'(PLAYER_WIDTH);
  localparam logic [10:0] PH11    = 11'(PLAYER_HEIGHT);
  localparam logic [10:0] CW11    = 11'(CAR_WIDTH);
  localparam logic [10:0] CH11    = 11'(CAR_HEIGHT);
  localparam logic [4:0]  SPD_MAX = 5'(SPEED_MAX);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MOVE_PERIOD - 1);
  localparam logic [IC_W-1:0] IC_LOAD = IC_W'(INVULN_CYCLES - 1);

  typedef enum logic [1:0] {S_PLAY, S_HIT, S_LVL, S_OVER} state_t;

  state_t            state, state_n;
  logic [MC_W-1:0]   move_cnt, move_cnt_n;
  logic [IC_W-1:0]   inv_cnt, inv_cnt_n;
  logic              hit_r, hit_any;
  logic [9:0]        px_n, py_n, mx, my;
  logic [LIVES-1:0]  lives_n;
  logic [3:0]        tens_n, units_n;
  logic [4:0]        speed_n;
  logic [10:0]       car_l, lane_t, px11, py11;
  logic              move_tc, soft_restart;

  assign soft_restart = SW1 & SW2 & SW3 & SW4;
  assign move_tc      = (move_cnt == MC_LAST);
  assign px11         = {1'b0, player_x};
  assign py11         = {1'b0, player_y};

  // Overlap test in 11 bits so edge sums near 1023 cannot wrap.
  always_comb begin
    hit_any = 1'b0;
    car_l   = '0;
    lane_t  = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      car_l  = {1'b0, car_x[10*i +: 10]};
      lane_t = 11'(LANE_Y0 + i * LANE_PITCH);
      if ((px11 + PW11 > car_l) && (px11 < car_l + CW11) &&
          (py11 + PH11 > lane_t) && (py11 < lane_t + CH11))
        hit_any = 1'b1;
    end
  end

  // Candidate position after this cycle's move opportunity. Only the
  // highest-priority held switch is considered; if it is blocked nothing moves.
  always_comb begin
    mx = player_x;
    my = player_y;
    if (move_tc) begin
      if (SW1) begin
        if (py11 >= STEP11) my = player_y - STEP10;
      end else if (SW2) begin
        if (py11 + STEP11 <= Y_MAX) my = player_y + STEP10;
      end else if (SW3) begin
        if (px11 >= STEP11) mx = player_x - STEP10;
      end else if (SW4) begin
        if (px11 + STEP11 <= X_MAX) mx = player_x + STEP10;
      end
    end
  end

  always_comb begin
    state_n    = state;
    move_cnt_n = move_tc ? '0 : move_cnt + MC_W'(1);
    inv_cnt_n  = inv_cnt;
    px_n       = player_x;
    py_n       = player_y;
    lives_n    = lives;
    tens_n     = level_tens;
    units_n    = level_units;
    speed_n    = speed_car;
    case (state)
      S_PLAY: begin
        if (hit_r) begin
          px_n = SPAWN_X;
          py_n = SPAWN_Y;
          if (lives == LIVES'(1)) begin
            lives_n    = '0;
            move_cnt_n = '0;
            state_n    = S_OVER;
          end else begin
            lives_n   = lives >> 1;
            inv_cnt_n = IC_LOAD;
            state_n   = S_HIT;
          end
        end else begin
          px_n = mx;
          py_n = my;
          if (player_y == 10'd0) state_n = S_LVL;
        end
      end
      S_HIT: begin
        // hit_r is ignored here, which also drops the pulse that caused entry
        px_n = mx;
        py_n = my;
        if (inv_cnt == '0) state_n = S_PLAY;
        else inv_cnt_n = inv_cnt - IC_W'(1);
      end
      S_LVL: begin
        if (level_units == 4'd9) begin
          if (level_tens != 4'd9) begin
            units_n = 4'd0;
            tens_n  = level_tens + 4'd1;
          end
        end else begin
          units_n = level_units + 4'd1;
        end
        if (speed_car != SPD_MAX) speed_n = speed_car + 5'd1;
        px_n    = SPAWN_X;
        py_n    = SPAWN_Y;
        state_n = S_PLAY;
      end
      default: begin
        move_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || soft_restart) begin
      state        <= S_PLAY;
      move_cnt     <= '0;
      inv_cnt      <= '0;
      hit_r        <= 1'b0;
      player_x     <= SPAWN_X;
      player_y     <= SPAWN_Y;
      lives        <= '1;
      level_tens   <= 4'd0;
      level_units  <= 4'd0;
      speed_car    <= 5'd0;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      move_cnt     <= move_cnt_n;
      inv_cnt      <= inv_cnt_n;
      hit_r        <= hit_any;
      player_x     <= px_n;
      player_y     <= py_n;
      lives        <= lives_n;
      level_tens   <= tens_n;
      level_units  <= units_n;
      speed_car    <= speed_n;
      invulnerable <= (state_n == S_HIT);
      game_over    <= (state_n == S_OVER);
    end
  end

endmodule
